utx_arb: RTL

Shares the single debug UART transmitter (16-bit word, tx_vld/tx_done handshake) between NREQ requesters, e.g. the chip data stream, register readback and the status beacon. Arbitration is round-robin at frame granularity: once a requester wins, it keeps the UART until it sends a word flagged last. The block sits between the requesters and the UART PHY, and supervises the PHY and the owner with timeouts.

---
 rtl/utx_arb.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/utx_arb.sv
// ---------------------------------------------------------------------------
// utx_arb -- round-robin arbiter that shares one debug UART transmitter
// between NREQ requesters at frame granularity.
//
// A requester that wins keeps the transmitter until it sends a word flagged
// last. The arbiter also supervises the PHY (tx_done wait) and the owner
// (next-word wait) with a common timeout. Any timeout releases the frame as
// if the last word had been sent.
//
// Ports
//   clk_sys   in   system clock
//   rst       in   asynchronous active-high reset
//   req_vld   in   [NREQ]     per-requester word valid, held until acked
//   req_last  in   [NREQ]     per-requester: current word ends the frame
//   req_data  in   [NREQ*DW]  packed words, requester i at [i*DW +: DW]
//   req_ack   out  [NREQ]     one-cycle pulse: word of requester i taken
//   gnt       out  [NREQ]     one-hot current owner, 0 when idle
//   tx_data   out  [DW]       word presented to the UART PHY
//   tx_vld    out             one-cycle start pulse to the PHY
//   tx_done   in              one-cycle pulse from the PHY: word shifted out
//   busy      out             high whenever the arbiter is not idle
//   err_tmo   out             one-cycle pulse on any timeout
//   err_cnt   out  [8]        saturating timeout count, cleared by reset
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module utx_arb #(
    parameter int NREQ    = 4,
    parameter int DW      = 16,
    parameter int TMO_CYC = 65535
) (
    input  logic               clk_sys,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_vld,
    input  logic [NREQ-1:0]    req_last,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ack,
    output logic [NREQ-1:0]    gnt,
    output logic [DW-1:0]      tx_data,
    output logic               tx_vld,
    input  logic               tx_done,
    output logic               busy,
    output logic               err_tmo,
    output logic [7:0]         err_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // The timer runs 0..TMO_CYC-1, so TMO_CYC cycles elapse before the
    // timeout fires.
    localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t          state_q, state_d;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [15:0]     timer_q, timer_d;
    logic            last_q, last_d;

    logic [NREQ-1:0] req_ack_q, req_ack_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [DW-1:0]   tx_data_q, tx_data_d;
    logic            tx_vld_q, tx_vld_d;
    logic            busy_q, busy_d;
    logic            err_tmo_q, err_tmo_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    // -----------------------------------------------------------------------
    // Unpack the requester words
    // -----------------------------------------------------------------------
    logic [DW-1:0] req_word [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_word
            assign req_word[gi] = req_data[gi*DW +: DW];
        end
    endgenerate

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
        if (idx == PW'(NREQ - 1)) begin
            return '0;
        end
        return idx + PW'(1);
    endfunction

    // -----------------------------------------------------------------------
    // Round-robin winner: first valid requester at ptr, ptr+1, ... mod NREQ
    // -----------------------------------------------------------------------
    logic          any_vld;
    logic [PW-1:0] win_idx;

    always_comb begin
        logic [PW:0] cand;
        any_vld = 1'b0;
        win_idx = ptr_q;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!any_vld && req_vld[cand[PW-1:0]]) begin
                any_vld = 1'b1;
                win_idx = cand[PW-1:0];
            end
        end
    end

    logic owner_vld;
    logic tmo_hit;

    assign owner_vld = req_vld[owner_q];
    assign tmo_hit   = (timer_q == TMO_LAST);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_vld) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A tx_done on the very cycle the timer expires still counts
                // as a successful transfer.
                if (tx_done) begin
                    state_d = last_q ? S_IDLE : S_HOLD;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (owner_vld) begin
                    state_d = S_SEND;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs and datapath next values
    // -----------------------------------------------------------------------
    logic          load_en;
    logic [PW-1:0] load_idx;
    logic          rel_en;
    logic          tmo_en;

    always_comb begin
        load_en  = 1'b0;
        load_idx = owner_q;
        rel_en   = 1'b0;
        tmo_en   = 1'b0;
        timer_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (any_vld) begin
                    load_en  = 1'b1;
                    load_idx = win_idx;
                end
            end
            S_SEND: begin
                timer_d = '0;
            end
            S_WAIT: begin
                timer_d = timer_q + 16'd1;
                if (tx_done) begin
                    timer_d = '0;
                    rel_en  = last_q;
                end else if (tmo_hit) begin
                    tmo_en = 1'b1;
                    rel_en = 1'b1;
                end
            end
            S_HOLD: begin
                timer_d = timer_q + 16'd1;
                if (owner_vld) begin
                    timer_d  = '0;
                    load_en  = 1'b1;
                    load_idx = owner_q;
                end else if (tmo_hit) begin
                    tmo_en = 1'b1;
                    rel_en = 1'b1;
                end
            end
            default: begin
                timer_d = '0;
            end
        endcase

        // Defaults: pulses drop, everything else holds.
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        tx_data_d = tx_data_q;
        tx_vld_d  = 1'b0;
        req_ack_d = '0;
        err_tmo_d = 1'b0;
        err_cnt_d = err_cnt_q;
        busy_d    = (state_d != S_IDLE);

        if (load_en) begin
            owner_d   = load_idx;
            gnt_d     = onehot(load_idx);
            tx_data_d = req_word[load_idx];
            tx_vld_d  = 1'b1;
            req_ack_d = onehot(load_idx);
            last_d    = req_last[load_idx];
        end

        // Releasing advances the pointer past the owner so the next frame
        // goes to someone else if anyone is waiting.
        if (rel_en) begin
            gnt_d = '0;
            ptr_d = next_idx(owner_q);
        end

        if (tmo_en) begin
            err_tmo_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath / output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            owner_q   <= '0;
            timer_q   <= '0;
            last_q    <= 1'b0;
            req_ack_q <= '0;
            gnt_q     <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_tmo_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            timer_q   <= timer_d;
            last_q    <= last_d;
            req_ack_q <= req_ack_d;
            gnt_q     <= gnt_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
            busy_q    <= busy_d;
            err_tmo_q <= err_tmo_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign req_ack = req_ack_q;
    assign gnt     = gnt_q;
    assign tx_data = tx_data_q;
    assign tx_vld  = tx_vld_q;
    assign busy    = busy_q;
    assign err_tmo = err_tmo_q;
    assign err_cnt = err_cnt_q;

endmodule
